// File: rtl/dma_cfg_pkg.sv
// ============================================================================
// Module      : dma_cfg_pkg
// Description : Register offsets, bit positions and encodings for the DMA
//               configuration register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_cfg_pkg;

  // Per-channel register offsets within a 0x20-byte channel block
  localparam logic [4:0] c_OFF_CTRL = 5'h00;
  localparam logic [4:0] c_OFF_SRC  = 5'h04;
  localparam logic [4:0] c_OFF_DST  = 5'h08;
  localparam logic [4:0] c_OFF_LEN  = 5'h0C;
  localparam logic [4:0] c_OFF_STAT = 5'h10;

  localparam int c_CHAN_STRIDE   = 32'h20;
  localparam int c_OFF_IRQ_STAT  = 32'h0;
  localparam int c_OFF_IRQ_MASK  = 32'h4;

  localparam int c_CTRL_EN       = 0;
  localparam int c_CTRL_MODE_LO  = 1;
  localparam int c_CTRL_IRQ_EN   = 3;
  localparam int c_CTRL_START    = 4;

  localparam int c_STAT_DONE     = 1;
  localparam int c_STAT_ERR      = 2;

  typedef enum logic [1:0] {
    MODE_MEM2MEM = 2'd0,
    MODE_MEM2IO  = 2'd1,
    MODE_IO2MEM  = 2'd2
  } dma_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } chan_state_e;

endpackage

`default_nettype wire

// File: rtl/dma_cfg_chan_fsm.sv
// ============================================================================
// Module      : dma_cfg_chan_fsm
// Description : Per-channel IDLE/ARM/RUN sequencer with arm timeout and
//               sticky done/err status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_cfg_chan_fsm
  import dma_cfg_pkg::*;
#(
  parameter int ARM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_req,
  input  logic        cfg_ok,
  input  logic        busy,
  input  logic        done,
  input  logic        error,
  input  logic        clr_done,
  input  logic        clr_err,
  output chan_state_e state,
  output logic        start,
  output logic        done_flag,
  output logic        err_flag
);

  localparam int c_CNT_W = $clog2(ARM_TIMEOUT) + 1;

  chan_state_e        r_state;
  chan_state_e        w_next_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_next_cnt;
  logic               r_done;
  logic               r_err;
  logic               w_set_done;
  logic               w_set_err;
  logic               w_clear_all;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      // A set in the same cycle as a W1C clear takes priority
      r_done  <= w_set_done | (r_done & ~clr_done & ~w_clear_all);
      r_err   <= w_set_err  | (r_err  & ~clr_err  & ~w_clear_all);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_set_done   = 1'b0;
    w_set_err    = 1'b0;
    w_clear_all  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_req) begin
          if (!cfg_ok) begin
            w_set_err = 1'b1;
          end else begin
            w_clear_all  = 1'b1;
            w_next_cnt   = '0;
            w_next_state = ST_ARM;
          end
        end
      end
      ST_ARM: begin
        if (busy) begin
          w_next_state = ST_RUN;
        end else if (r_cnt == c_CNT_W'(ARM_TIMEOUT - 1)) begin
          w_set_err    = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_next_cnt = r_cnt + c_CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (error) begin
          w_set_err    = 1'b1;
          w_next_state = ST_IDLE;
        end else if (done) begin
          w_set_done   = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign state     = r_state;
  assign start     = (r_state == ST_ARM);
  assign done_flag = r_done;
  assign err_flag  = r_err;

endmodule

`default_nettype wire

// File: rtl/dma_cfg_regfile.sv
// ============================================================================
// Module      : dma_cfg_regfile
// Description : Register-mapped DMA channel configuration, sticky status and
//               level interrupt front-end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_cfg_regfile
  import dma_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int CHANNEL_COUNT = 4,
  parameter int REG_AW        = 12,
  parameter int ARM_TIMEOUT   = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [REG_AW-1:0]                 reg_addr,
  input  logic                              reg_wr,
  input  logic [31:0]                       reg_wdata,
  input  logic                              reg_rd,
  output logic [31:0]                       reg_rdata,
  output logic                              reg_rvalid,
  output logic [CHANNEL_COUNT-1:0]          channel_enable,
  output logic [CHANNEL_COUNT*ADDR_WIDTH-1:0] channel_src_addr,
  output logic [CHANNEL_COUNT*ADDR_WIDTH-1:0] channel_dst_addr,
  output logic [CHANNEL_COUNT*32-1:0]       channel_length,
  output logic [CHANNEL_COUNT*2-1:0]        channel_mode,
  output logic [CHANNEL_COUNT-1:0]          channel_start,
  input  logic [CHANNEL_COUNT-1:0]          channel_busy,
  input  logic [CHANNEL_COUNT-1:0]          channel_done,
  input  logic [CHANNEL_COUNT-1:0]          channel_error,
  output logic                              irq
);

  localparam int          c_GBASE     = CHANNEL_COUNT * c_CHAN_STRIDE;
  localparam logic [REG_AW-1:0] c_IRQ_STAT_A = REG_AW'(c_GBASE + c_OFF_IRQ_STAT);
  localparam logic [REG_AW-1:0] c_IRQ_MASK_A = REG_AW'(c_GBASE + c_OFF_IRQ_MASK);

  logic [REG_AW-1:0]        w_addr;
  logic                     w_unused_addr_lsb;
  logic [CHANNEL_COUNT-1:0] w_irq_stat;
  logic [31:0]              w_ctrl_rd [CHANNEL_COUNT];
  logic [31:0]              w_src_rd  [CHANNEL_COUNT];
  logic [31:0]              w_dst_rd  [CHANNEL_COUNT];
  logic [31:0]              w_len_rd  [CHANNEL_COUNT];
  logic [31:0]              w_stat_rd [CHANNEL_COUNT];
  logic [31:0]              w_rd_data;
  logic                     r_irq_mask;
  logic                     r_irq;
  logic                     r_rvalid;
  logic [31:0]              r_rdata;

  assign w_addr            = {reg_addr[REG_AW-1:2], 2'b00};
  assign w_unused_addr_lsb = ^reg_addr[1:0];

  for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_chan
    logic                  w_sel;
    logic                  w_idle;
    logic                  w_wr_ctrl;
    logic                  w_wr_src;
    logic                  w_wr_dst;
    logic                  w_wr_len;
    logic                  w_wr_stat;
    chan_state_e           w_state;
    logic                  w_done;
    logic                  w_err;
    logic                  r_en;
    logic [1:0]            r_mode;
    logic                  r_irq_en;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [31:0]           r_len;

    assign w_sel     = (w_addr[REG_AW-1:5] == (REG_AW-5)'(i));
    assign w_idle    = (w_state == ST_IDLE);
    assign w_wr_ctrl = reg_wr & w_sel & (w_addr[4:0] == c_OFF_CTRL);
    assign w_wr_src  = reg_wr & w_sel & (w_addr[4:0] == c_OFF_SRC);
    assign w_wr_dst  = reg_wr & w_sel & (w_addr[4:0] == c_OFF_DST);
    assign w_wr_len  = reg_wr & w_sel & (w_addr[4:0] == c_OFF_LEN);
    assign w_wr_stat = reg_wr & w_sel & (w_addr[4:0] == c_OFF_STAT);

    // Transfer parameters are frozen while the channel is active; irq_en is not
    always_ff @(posedge clk) begin
      if (rst) begin
        r_en     <= 1'b0;
        r_mode   <= 2'b00;
        r_irq_en <= 1'b0;
        r_src    <= '0;
        r_dst    <= '0;
        r_len    <= '0;
      end else begin
        if (w_wr_ctrl && w_idle) begin
          r_en   <= reg_wdata[c_CTRL_EN];
          r_mode <= reg_wdata[c_CTRL_MODE_LO +: 2];
        end
        if (w_wr_ctrl) r_irq_en <= reg_wdata[c_CTRL_IRQ_EN];
        if (w_wr_src && w_idle) r_src <= reg_wdata[ADDR_WIDTH-1:0];
        if (w_wr_dst && w_idle) r_dst <= reg_wdata[ADDR_WIDTH-1:0];
        if (w_wr_len && w_idle) r_len <= reg_wdata;
      end
    end

    dma_cfg_chan_fsm #(
      .ARM_TIMEOUT (ARM_TIMEOUT)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .start_req (w_wr_ctrl & reg_wdata[c_CTRL_START]),
      .cfg_ok    ((r_len != 32'd0) & reg_wdata[c_CTRL_EN]),
      .busy      (channel_busy[i]),
      .done      (channel_done[i]),
      .error     (channel_error[i]),
      .clr_done  (w_wr_stat & reg_wdata[c_STAT_DONE]),
      .clr_err   (w_wr_stat & reg_wdata[c_STAT_ERR]),
      .state     (w_state),
      .start     (channel_start[i]),
      .done_flag (w_done),
      .err_flag  (w_err)
    );

    assign channel_enable[i]                          = r_en;
    assign channel_mode[i*2 +: 2]                     = r_mode;
    assign channel_src_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = r_src;
    assign channel_dst_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = r_dst;
    assign channel_length[i*32 +: 32]                 = r_len;
    assign w_irq_stat[i]                              = (w_done | w_err) & r_irq_en;

    assign w_ctrl_rd[i] = {28'd0, r_irq_en, r_mode, r_en};
    assign w_src_rd[i]  = 32'(r_src);
    assign w_dst_rd[i]  = 32'(r_dst);
    assign w_len_rd[i]  = r_len;
    assign w_stat_rd[i] = {26'd0, w_state, (w_state == ST_ARM), w_err, w_done, channel_busy[i]};
  end

  always_comb begin
    w_rd_data = 32'd0;
    for (int k = 0; k < CHANNEL_COUNT; k++) begin
      if (w_addr[REG_AW-1:5] == (REG_AW-5)'(k)) begin
        case (w_addr[4:0])
          c_OFF_CTRL: w_rd_data = w_ctrl_rd[k];
          c_OFF_SRC:  w_rd_data = w_src_rd[k];
          c_OFF_DST:  w_rd_data = w_dst_rd[k];
          c_OFF_LEN:  w_rd_data = w_len_rd[k];
          c_OFF_STAT: w_rd_data = w_stat_rd[k];
          default:    w_rd_data = 32'd0;
        endcase
      end
    end
    if (w_addr == c_IRQ_STAT_A) w_rd_data = 32'(w_irq_stat);
    if (w_addr == c_IRQ_MASK_A) w_rd_data = {31'd0, r_irq_mask};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_mask <= 1'b0;
      r_irq      <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= 32'd0;
    end else begin
      if (reg_wr && (w_addr == c_IRQ_MASK_A)) r_irq_mask <= reg_wdata[0];
      r_irq    <= r_irq_mask & (|w_irq_stat);
      r_rvalid <= reg_rd;
      if (reg_rd) r_rdata <= w_rd_data;
    end
  end

  assign irq        = r_irq;
  assign reg_rvalid = r_rvalid;
  assign reg_rdata  = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dma_cfg_regfile.sv
// ============================================================================
// Module      : tb_dma_cfg_regfile
// Description : Directed self-checking bench for dma_cfg_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_cfg_regfile;

  localparam int ADDR_WIDTH    = 32;
  localparam int CHANNEL_COUNT = 4;
  localparam int REG_AW        = 12;
  localparam int ARM_TIMEOUT   = 64;

  logic                                clk;
  logic                                rst;
  logic [REG_AW-1:0]                   reg_addr;
  logic                                reg_wr;
  logic [31:0]                         reg_wdata;
  logic                                reg_rd;
  logic [31:0]                         reg_rdata;
  logic                                reg_rvalid;
  logic [CHANNEL_COUNT-1:0]            channel_enable;
  logic [CHANNEL_COUNT*ADDR_WIDTH-1:0] channel_src_addr;
  logic [CHANNEL_COUNT*ADDR_WIDTH-1:0] channel_dst_addr;
  logic [CHANNEL_COUNT*32-1:0]         channel_length;
  logic [CHANNEL_COUNT*2-1:0]          channel_mode;
  logic [CHANNEL_COUNT-1:0]            channel_start;
  logic [CHANNEL_COUNT-1:0]            channel_busy;
  logic [CHANNEL_COUNT-1:0]            channel_done;
  logic [CHANNEL_COUNT-1:0]            channel_error;
  logic                                irq;

  int n_assert;
  int n_fail;

  dma_cfg_regfile #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .CHANNEL_COUNT (CHANNEL_COUNT),
    .REG_AW        (REG_AW),
    .ARM_TIMEOUT   (ARM_TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .reg_addr         (reg_addr),
    .reg_wr           (reg_wr),
    .reg_wdata        (reg_wdata),
    .reg_rd           (reg_rd),
    .reg_rdata        (reg_rdata),
    .reg_rvalid       (reg_rvalid),
    .channel_enable   (channel_enable),
    .channel_src_addr (channel_src_addr),
    .channel_dst_addr (channel_dst_addr),
    .channel_length   (channel_length),
    .channel_mode     (channel_mode),
    .channel_start    (channel_start),
    .channel_busy     (channel_busy),
    .channel_done     (channel_done),
    .channel_error    (channel_error),
    .irq              (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [REG_AW-1:0] addr, input logic [31:0] data);
    reg_addr  = addr;
    reg_wdata = data;
    reg_wr    = 1'b1;
    tick();
    reg_wr    = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [REG_AW-1:0] addr, input logic [31:0] exp);
    reg_addr = addr;
    reg_rd   = 1'b1;
    tick();
    reg_rd   = 1'b0;
    chk({tag, "_rvalid"}, 128'(reg_rvalid), 128'd1);
    chk(tag, 128'(reg_rdata), 128'(exp));
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    reg_addr      = '0;
    reg_wr        = 1'b0;
    reg_wdata     = 32'd0;
    reg_rd        = 1'b0;
    channel_busy  = '0;
    channel_done  = '0;
    channel_error = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_start",  128'(channel_start),    128'd0);
    chk("rst_enable", 128'(channel_enable),   128'd0);
    chk("rst_src",    128'(channel_src_addr), 128'd0);
    chk("rst_len",    128'(channel_length),   128'd0);
    chk("rst_irq",    128'(irq),              128'd0);
    chk("rst_rvalid", 128'(reg_rvalid),       128'd0);
    chk("rst_rdata",  128'(reg_rdata),        128'd0);
    rd_chk("rst_stat0", 12'h010, 32'h0);
    rd_chk("rst_stat1", 12'h030, 32'h0);
    rd_chk("rst_stat2", 12'h050, 32'h0);
    rd_chk("rst_stat3", 12'h070, 32'h0);
    rd_chk("rst_irqstat", 12'h080, 32'h0);
    tick();
    chk("rvalid_one_cycle", 128'(reg_rvalid), 128'd0);
    rd_chk("unmapped_ch", 12'h014, 32'h0);
    rd_chk("unmapped_g",  12'h088, 32'h0);

    // Channel 1 normal transfer
    wr(12'h024, 32'h1000);
    wr(12'h028, 32'h2000);
    wr(12'h02C, 32'd4);
    chk("ch1_src_out", 128'(channel_src_addr[63:32]), 128'h1000);
    chk("ch1_dst_out", 128'(channel_dst_addr[63:32]), 128'h2000);
    chk("ch1_len_out", 128'(channel_length[63:32]),   128'd4);
    wr(12'h020, 32'h13);
    chk("ch1_start_arm", 128'(channel_start),  128'b0010);
    chk("ch1_enable",    128'(channel_enable), 128'b0010);
    chk("ch1_mode",      128'(channel_mode),   128'b0100);
    rd_chk("ch1_stat_arm", 12'h030, 32'h18);
    rd_chk("ch1_ctrl",     12'h020, 32'h03);
    chk("ch1_start_held", 128'(channel_start), 128'b0010);
    channel_busy = 4'b0010;
    tick();
    chk("ch1_start_drop", 128'(channel_start), 128'b0000);
    rd_chk("ch1_stat_run", 12'h030, 32'h21);
    channel_busy = 4'b0000;
    channel_done = 4'b0010;
    tick();
    channel_done = 4'b0000;
    rd_chk("ch1_stat_done", 12'h030, 32'h2);

    // Channel 0 completion interrupt
    wr(12'h084, 32'h1);
    rd_chk("irq_mask", 12'h084, 32'h1);
    wr(12'h004, 32'h10);
    wr(12'h00C, 32'd2);
    wr(12'h000, 32'h19);
    channel_busy = 4'b0001;
    tick();
    channel_busy = 4'b0000;
    channel_done = 4'b0001;
    tick();
    channel_done = 4'b0000;
    chk("irq_not_yet", 128'(irq), 128'd0);
    tick();
    chk("irq_set", 128'(irq), 128'd1);
    rd_chk("irq_stat_ch0", 12'h080, 32'h1);
    wr(12'h010, 32'h2);
    chk("irq_still_set", 128'(irq), 128'd1);
    tick();
    chk("irq_cleared", 128'(irq), 128'd0);
    rd_chk("ch0_stat_clr", 12'h010, 32'h0);

    // Channel 2 error paths
    wr(12'h040, 32'h11);
    chk("len0_no_start", 128'(channel_start), 128'd0);
    tick();
    chk("len0_no_start2", 128'(channel_start), 128'd0);
    rd_chk("len0_err", 12'h050, 32'h4);
    wr(12'h050, 32'h4);
    rd_chk("err_w1c", 12'h050, 32'h0);
    wr(12'h04C, 32'd5);
    wr(12'h040, 32'h10);
    chk("en0_no_start", 128'(channel_start), 128'd0);
    chk("en0_enable",   128'(channel_enable[2]), 128'd0);
    rd_chk("en0_err", 12'h050, 32'h4);
    wr(12'h040, 32'h11);
    chk("to_start_c1", 128'(channel_start), 128'b0100);
    repeat (ARM_TIMEOUT - 1) tick();
    chk("to_start_c64", 128'(channel_start), 128'b0100);
    tick();
    chk("to_start_c65", 128'(channel_start), 128'b0000);
    rd_chk("to_err", 12'h050, 32'h4);

    // Channel 2 lock while running, then done set racing its W1C clear
    wr(12'h044, 32'h3000);
    wr(12'h040, 32'h11);
    channel_busy = 4'b0100;
    tick();
    wr(12'h044, 32'hDEAD);
    chk("lock_src_out", 128'(channel_src_addr[95:64]), 128'h3000);
    rd_chk("lock_src_rd", 12'h044, 32'h3000);
    wr(12'h040, 32'h08);
    chk("lock_enable", 128'(channel_enable[2]), 128'd1);
    rd_chk("lock_ctrl", 12'h040, 32'h09);
    channel_busy = 4'b0000;
    channel_done = 4'b0100;
    wr(12'h050, 32'h2);
    channel_done = 4'b0000;
    rd_chk("done_set_wins", 12'h050, 32'h2);
    rd_chk("irq_stat_ch2", 12'h080, 32'h4);
    chk("irq_ch2", 128'(irq), 128'd1);

    // Same-cycle read and write returns the old value
    reg_addr  = 12'h044;
    reg_wdata = 32'h5555;
    reg_wr    = 1'b1;
    reg_rd    = 1'b1;
    tick();
    reg_wr    = 1'b0;
    reg_rd    = 1'b0;
    chk("rdwr_old", 128'(reg_rdata), 128'h3000);
    rd_chk("rdwr_new", 12'h044, 32'h5555);

    // Reset in the middle of a channel 3 transfer
    wr(12'h06C, 32'd8);
    wr(12'h060, 32'h15);
    chk("ch3_start", 128'(channel_start), 128'b1000);
    chk("ch3_mode",  128'(channel_mode[7:6]), 128'd2);
    channel_busy = 4'b1000;
    tick();
    rd_chk("ch3_stat_run", 12'h070, 32'h21);
    rst = 1'b1;
    tick();
    channel_busy = 4'b0000;
    chk("rst2_start",  128'(channel_start),  128'd0);
    chk("rst2_enable", 128'(channel_enable), 128'd0);
    chk("rst2_len",    128'(channel_length), 128'd0);
    chk("rst2_src",    128'(channel_src_addr), 128'd0);
    chk("rst2_mode",   128'(channel_mode),   128'd0);
    chk("rst2_irq",    128'(irq),            128'd0);
    chk("rst2_rdata",  128'(reg_rdata),      128'd0);
    rst = 1'b0;
    tick();
    rd_chk("rst2_stat3", 12'h070, 32'h0);
    rd_chk("rst2_mask",  12'h084, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dma_cfg_regfile.md
Name: dma_cfg_regfile

Overview:
- Register-mapped configuration and status front-end that sits directly upstream of the DMA controller.
- Host writes per-channel source, destination, length, mode and enable over a simple single-cycle register bus.
- Block drives the controller's per-channel config vectors and a held start level, and collects done/error into sticky status.
- Raises one level interrupt line.

Parameters:
- ADDR_WIDTH, 32, width of src/dst address fields.
- CHANNEL_COUNT, 4, number of DMA channels; legal range 1..8.
- REG_AW, 12, register bus byte-address width.
- ARM_TIMEOUT, 64, cycles to wait for channel_busy after arming before declaring error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- reg_addr  in  REG_AW  byte address; word aligned, bits[1:0] ignored
- reg_wr  in  1  write strobe, one cycle per write
- reg_wdata  in  32  write data
- reg_rd  in  1  read strobe
- reg_rdata  out  32  read data, valid when reg_rvalid=1
- reg_rvalid  out  1  read response, exactly 1 cycle after reg_rd
- channel_enable  out  CHANNEL_COUNT  per-channel enable
- channel_src_addr  out  CHANNEL_COUNT*ADDR_WIDTH  packed, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- channel_dst_addr  out  CHANNEL_COUNT*ADDR_WIDTH  packed, same layout
- channel_length  out  CHANNEL_COUNT*32  packed transfer count in words
- channel_mode  out  CHANNEL_COUNT*2  0=mem2mem, 1=mem2io, 2=io2mem
- channel_start  out  CHANNEL_COUNT  held start level
- channel_busy  in  CHANNEL_COUNT  from controller
- channel_done  in  CHANNEL_COUNT  from controller
- channel_error  in  CHANNEL_COUNT  from controller
- irq  out  1  level interrupt

Behaviour:
- Register map: channel i block at base i*0x20.
  - CTRL +0x00: [0] enable, [2:1] mode, [3] irq_en, [4] start (write-1 only, reads 0).
  - SRC +0x04, DST +0x08, LEN +0x0C.
  - STAT +0x10 (read-only except W1C bits): [0] busy (live input), [1] done (sticky, W1C), [2] err (sticky, W1C), [3] armed, [5:4] fsm state.
- Global registers at base G = CHANNEL_COUNT*0x20:
  - IRQ_STAT G+0x0: bit i = (done_i | err_i) & irq_en_i, read-only.
  - IRQ_MASK G+0x4: global irq enable, bit0, reset 0.
- Unmapped reads return 0; unmapped writes are ignored.
- Reset: all config fields, sticky bits, IRQ_MASK, channel_start, reg_rvalid, reg_rdata and irq are 0; every per-channel FSM is in IDLE.
- Outputs channel_enable/src/dst/length/mode are direct register contents with zero added latency.
- Lock: while channel FSM != IDLE, writes to that channel's SRC/DST/LEN and to CTRL[2:0] are ignored. CTRL[3] (irq_en) stays writable.
- Per-channel FSM (IDLE, ARM, RUN):
  - IDLE: write CTRL with [4]=1:
    - If LEN==0 or enable==0 (after applying the same write's enable bit): set err, stay IDLE, no start.
    - Otherwise clear done/err, go to ARM. channel_start=1 from the next cycle.
  - ARM: hold channel_start=1 and count cycles.
    - channel_busy=1 -> drop channel_start next cycle, go to RUN.
    - Count reaches ARM_TIMEOUT -> set err, channel_start=0, go to IDLE.
  - RUN: channel_start=0.
    - channel_error=1 -> set err, go to IDLE.
    - Else channel_done=1 -> set done, go to IDLE.
    - If both are high in the same cycle, only err is set.
  - start writes in ARM/RUN are ignored and do not set err.
- Sticky set and W1C clear in the same cycle: set wins.
- irq = IRQ_MASK[0] & |IRQ_STAT, registered, so 1 cycle after the status change.
- Read mux is registered: reg_rdata updates with reg_rvalid and holds its value otherwise.
- reg_rd and reg_wr in the same cycle to the same address: read returns the pre-write value.
- rst asserted mid-transfer: FSM returns to IDLE and channel_start drops the next cycle. The controller is expected to be reset by the same rst.

Decomposition:
- Package dma_cfg_pkg holds:
  - register offsets (CTRL/SRC/DST/LEN/STAT, channel stride 0x20, IRQ_STAT/IRQ_MASK);
  - CTRL/STAT bit positions;
  - mode encodings;
  - FSM state encoding (2 bits: IDLE=0, ARM=1, RUN=2).
- Sub-module dma_cfg_chan_fsm: one instance per channel. Holds the ARM/RUN FSM, timeout counter and done/err sticky bits.
- Top level keeps the register storage, address decode and read mux.

Test Plan:
- Reset: after rst all outputs are 0, every STAT reads 0x0, and IRQ_STAT reads 0.
- Program ch1: SRC=0x1000, DST=0x2000, LEN=4, CTRL=0x13 (start, enable, mode=1) -> channel_start[1]=1 next cycle. Model busy rising 3 cycles later -> start drops 1 cycle after busy. Pulse done -> STAT1=0x2, FSM IDLE.
- With CTRL irq_en=1 and IRQ_MASK=1, ch0 completes -> irq=1 one cycle after the done bit sets. W1C STAT0 bit1 -> irq=0 one cycle later.
- Start with LEN=0 -> err set, channel_start never asserts. Start with enable=0 -> err set. Start with busy tied low -> err after ARM_TIMEOUT=64 cycles, channel_start low on cycle 65.
- Lock: while ch2 is RUN, write SRC=0xDEAD -> read-back and output stay old. Simultaneous done and W1C of done -> done remains 1.
- Assert rst while ch3 is RUN -> channel_start[3]=0, STAT3=0, outputs back at reset values one cycle later.
